multicycle_datapath: RTL and testbench

- Parametrised multicycle RV32/RV64 integer datapath, the successor to the single-cycle core datapath.
- Accepts one decoded instruction per issue handshake and owns the register file.
- Sequences execute, memory and writeback over several clock cycles, with a stallable request/ready memory port and byte-lane load/store handling.
- Reports next PC and completion to the control unit.

---
 rtl/multicycle_datapath.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle RV32/RV64 integer datapath: owns the register file and walks each
// issued instruction through EXEC, an optional stallable MEM phase, and WB.
module multicycle_datapath #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op_class,
  input  logic              u_lui,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [3:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   next_pc,
  output logic              trap_misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB  = XLEN / 8;
  localparam int OW  = $clog2(NB);
  localparam int SHW = $clog2(XLEN);
  localparam int AW  = $clog2(REG_COUNT);
  localparam logic [5:0] REG_LIM = 6'(REG_COUNT);

  localparam logic [2:0] OP_R     = 3'd0;
  localparam logic [2:0] OP_I     = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STORE = 3'd3;
  localparam logic [2:0] OP_BR    = 3'd4;
  localparam logic [2:0] OP_JAL   = 3'd5;
  localparam logic [2:0] OP_JALR  = 3'd6;
  localparam logic [2:0] OP_U     = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_e;

  // Handshakes: start is taken only when busy is low and is acknowledged by a
  // single-cycle done; mem_req stays high with mem_addr/mem_we/mem_wdata/
  // mem_wstrb stable until the cycle mem_ready is high, which completes it.
  state_e            state_q, state_d;
  logic [2:0]        op_class_q, op_class_d;
  logic              u_lui_q, u_lui_d;
  logic [4:0]        rd_q, rd_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;
  logic [XLEN-1:0]   next_pc_q, next_pc_d;
  logic              trap_q, trap_d;

  logic [XLEN-1:0]   regs_q [REG_COUNT];

  function automatic logic reg_ok(input logic [4:0] a);
    return {1'b0, a} < REG_LIM;
  endfunction

  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (reg_ok(rs1)) rs1_val = regs_q[rs1[AW-1:0]];
    if (reg_ok(rs2)) rs2_val = regs_q[rs2[AW-1:0]];
  end

  // Execute-stage combinational logic, all fed from the captured operands.
  logic [XLEN-1:0] alu_b, alu_res, eff_addr, pc_plus4, pc_plus_imm, exec_res;
  logic [SHW-1:0]  shamt;
  logic [1:0]      size;
  logic [OW-1:0]   offs;
  logic            is_mem, misaligned, taken;
  logic [NB-1:0]   strb_base;
  logic [XLEN-1:0] store_data;

  always_comb begin
    alu_b    = (op_class_q == OP_R) ? b_q : imm_q;
    shamt    = alu_b[SHW-1:0];
    alu_res  = '0;
    case (alu_op_q[2:0])
      3'd0: alu_res = alu_op_q[3] ? (a_q - alu_b) : (a_q + alu_b);
      3'd1: alu_res = a_q << shamt;
      3'd2: alu_res = XLEN'($signed(a_q) < $signed(alu_b));
      3'd3: alu_res = XLEN'(a_q < alu_b);
      3'd4: alu_res = a_q ^ alu_b;
      3'd5: alu_res = alu_op_q[3] ? XLEN'($signed(a_q) >>> shamt) : (a_q >> shamt);
      3'd6: alu_res = a_q | alu_b;
      default: alu_res = a_q & alu_b;
    endcase

    eff_addr    = a_q + imm_q;
    pc_plus4    = pc_q + XLEN'(4);
    pc_plus_imm = pc_q + imm_q;
    size        = funct3_q[1:0];
    offs        = eff_addr[OW-1:0];
    is_mem      = (op_class_q == OP_LOAD) || (op_class_q == OP_STORE);

    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = eff_addr[0];
      2'd2:    misaligned = (eff_addr[1:0] != 2'd0);
      default: misaligned = (XLEN < 64) || (eff_addr[2:0] != 3'd0);
    endcase

    case (funct3_q)
      3'd0:    taken = (a_q == b_q);
      3'd1:    taken = (a_q != b_q);
      3'd4:    taken = ($signed(a_q) < $signed(b_q));
      3'd5:    taken = ($signed(a_q) >= $signed(b_q));
      3'd6:    taken = (a_q < b_q);
      3'd7:    taken = (a_q >= b_q);
      default: taken = 1'b0;
    endcase

    case (op_class_q)
      OP_R, OP_I:       exec_res = alu_res;
      OP_JAL, OP_JALR:  exec_res = pc_plus4;
      OP_U:             exec_res = u_lui_q ? imm_q : pc_plus_imm;
      default:          exec_res = '0;
    endcase

    case (size)
      2'd0:    begin strb_base = NB'(1);  store_data = {NB{b_q[7:0]}};        end
      2'd1:    begin strb_base = NB'(3);  store_data = {(NB/2){b_q[15:0]}};   end
      2'd2:    begin strb_base = NB'(15); store_data = {(NB/4){b_q[31:0]}};   end
      default: begin strb_base = '1;      store_data = b_q;                   end
    endcase
  end

  // Load lane extraction works from the registered address of the access.
  logic [XLEN-1:0] ld_shift, ld_mask, load_val;
  logic            ld_sign;

  always_comb begin
    ld_shift = mem_rdata >> {addr_q[OW-1:0], 3'b000};
    case (funct3_q[1:0])
      2'd0:    begin ld_mask = XLEN'(8'hFF);         ld_sign = ld_shift[7];      end
      2'd1:    begin ld_mask = XLEN'(16'hFFFF);      ld_sign = ld_shift[15];     end
      2'd2:    begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sign = ld_shift[31];     end
      default: begin ld_mask = '1;                   ld_sign = ld_shift[XLEN-1]; end
    endcase
    load_val = ld_shift & ld_mask;
    if (!funct3_q[2] && ld_sign) load_val = load_val | ~ld_mask;
  end

  always_comb begin
    state_d    = state_q;
    op_class_d = op_class_q;
    u_lui_d    = u_lui_q;
    rd_d       = rd_q;
    alu_op_d   = alu_op_q;
    funct3_d   = funct3_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    next_pc_d  = next_pc_q;
    trap_d     = trap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_class_d = op_class;
          u_lui_d    = u_lui;
          rd_d       = rd;
          alu_op_d   = alu_op;
          funct3_d   = funct3;
          imm_d      = imm;
          pc_d       = pc;
          a_d        = rs1_val;
          b_d        = rs2_val;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = exec_res;
        addr_d   = eff_addr;
        wdata_d  = store_data;
        wstrb_d  = strb_base << offs;
        trap_d   = is_mem && misaligned;
        if (is_mem && misaligned)
          next_pc_d = pc_q;
        else if ((op_class_q == OP_JAL) || ((op_class_q == OP_BR) && taken))
          next_pc_d = pc_plus_imm;
        else if (op_class_q == OP_JALR)
          next_pc_d = {eff_addr[XLEN-1:1], 1'b0};
        else
          next_pc_d = pc_plus4;
        state_d = (is_mem && !misaligned) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op_class_q == OP_LOAD) result_d = load_val;
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_class_q <= '0;
      u_lui_q    <= 1'b0;
      rd_q       <= '0;
      alu_op_q   <= '0;
      funct3_q   <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      next_pc_q  <= '0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_class_q <= op_class_d;
      u_lui_q    <= u_lui_d;
      rd_q       <= rd_d;
      alu_op_q   <= alu_op_d;
      funct3_q   <= funct3_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      next_pc_q  <= next_pc_d;
      trap_q     <= trap_d;
    end
  end

  // Stores and branches never write; x0 and out-of-range rd are dropped.
  logic rf_we;

  always_comb begin
    rf_we = (state_q == S_WB) && !trap_q && (rd_q != 5'd0) && reg_ok(rd_q) &&
            (op_class_q != OP_STORE) && (op_class_q != OP_BR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rd_q[AW-1:0]] <= result_q;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_WB);
  assign next_pc         = next_pc_q;
  assign trap_misaligned = done && trap_q;
  assign mem_req         = (state_q == S_MEM);
  assign mem_we          = mem_req && (op_class_q == OP_STORE);
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_wstrb       = wstrb_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath (XLEN=32): vector table of
// non-memory instructions plus directed load/store/trap/reset sequences.
module tb_multicycle_datapath;

  localparam logic [2:0] OP_R = 3'd0, OP_I = 3'd1, OP_LD = 3'd2, OP_ST = 3'd3;
  localparam logic [2:0] OP_BR = 3'd4, OP_JAL = 3'd5, OP_JALR = 3'd6, OP_U = 3'd7;

  typedef struct packed {
    logic [2:0]  cls;
    logic        u;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
  } instr_t;

  typedef struct packed {
    instr_t      ins;
    logic [31:0] exp_npc;
    logic [4:0]  chk_reg;
    logic [31:0] chk_val;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op_class = '0;
  logic        u_lui = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [3:0]  alu_op = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] imm = '0, pc = '0;
  logic        busy, done, trap_misaligned, mem_req, mem_we;
  logic [31:0] next_pc, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  multicycle_datapath dut (
    .clk(clk), .rst(rst), .start(start), .op_class(op_class), .u_lui(u_lui),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op), .funct3(funct3),
    .imm(imm), .pc(pc), .busy(busy), .done(done), .next_pc(next_pc),
    .trap_misaligned(trap_misaligned), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];

  int          r_done_cyc, r_req;
  logic        r_we, r_trap, r_addr_stable;
  logic [31:0] r_addr, r_wdata, r_npc;
  logic [3:0]  r_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [2:0] cls, input logic u, input logic [3:0] alu,
                                input logic [2:0] f3, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] d, input logic [31:0] im, input logic [31:0] p);
    instr_t t;
    t.cls = cls; t.u = u; t.alu = alu; t.f3 = f3;
    t.rs1 = a; t.rs2 = b; t.rd = d; t.imm = im; t.pc = p;
    return t;
  endfunction

  task automatic drive(input instr_t t);
    op_class = t.cls; u_lui = t.u; alu_op = t.alu; funct3 = t.f3;
    rs1 = t.rs1; rs2 = t.rs2; rd = t.rd; imm = t.imm; pc = t.pc;
  endtask

  // Issue one instruction, act as memory with `delay` wait cycles, and
  // compare the completion against the scoreboard entry pushed here.
  task automatic run_instr(input instr_t t, input int delay, input logic [31:0] rdata,
                           input logic [31:0] exp_npc, input logic exp_trap);
    int cyc, waited;
    logic got;
    logic [32:0] e;
    exp_q.push_back({exp_trap, exp_npc});
    @(negedge clk);
    chk("idle_before_issue", {busy, done}, 2'b00);
    drive(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; waited = 0; got = 1'b0;
    r_req = 0; r_we = 1'b0; r_addr = '0; r_wdata = '0; r_wstrb = '0; r_addr_stable = 1'b1;
    while (!got && cyc < 200) begin
      if (done) begin
        got = 1'b1;
        r_done_cyc = cyc;
        r_npc = next_pc;
        r_trap = trap_misaligned;
        mem_ready = 1'b0;
      end else begin
        if (mem_req) begin
          if (r_req > 0 && mem_addr !== r_addr) r_addr_stable = 1'b0;
          r_req++;
          r_we = mem_we; r_addr = mem_addr; r_wdata = mem_wdata; r_wstrb = mem_wstrb;
          if (waited == delay) begin
            mem_ready = 1'b1;
            mem_rdata = rdata;
          end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
          end
          waited++;
        end else begin
          mem_ready = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    e = exp_q.pop_front();
    if (!got) begin
      total++;
      bad++;
      r_done_cyc = -1;
      $display("FAIL done_timeout: no done within 200 cycles, pc=0x%0h", t.pc);
    end else begin
      chk("next_pc", r_npc, e[31:0]);
      chk("trap_misaligned", r_trap, e[32]);
    end
  endtask

  // Observe a register by storing it as a word and checking the bus data.
  task automatic check_reg(input logic [4:0] n, input logic [31:0] v);
    run_instr(mk(OP_ST, 1'b0, 4'd0, 3'd2, 5'd0, n, 5'd0, 32'h200, 32'h300), 0, '0,
              32'h304, 1'b0);
    chk($sformatf("reg_x%0d", n), r_wdata, v);
  endtask

  vec_t vt[$];

  task automatic add_vec(input instr_t t, input logic [31:0] npc, input logic [4:0] r,
                         input logic [31:0] v);
    vec_t x;
    x.ins = t; x.exp_npc = npc; x.chk_reg = r; x.chk_val = v;
    vt.push_back(x);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc;
    logic seen;

    add_vec(mk(OP_I,  0, 4'd0,  3'd0, 5'd0,  5'd0,  5'd1,  32'd5,        32'h000), 32'h004, 5'd1,  32'd5);
    add_vec(mk(OP_I,  0, 4'd0,  3'd0, 5'd0,  5'd0,  5'd2,  32'd7,        32'h004), 32'h008, 5'd2,  32'd7);
    add_vec(mk(OP_R,  0, 4'd0,  3'd0, 5'd1,  5'd2,  5'd3,  32'd0,        32'h008), 32'h00C, 5'd3,  32'd12);
    add_vec(mk(OP_U,  1, 4'd0,  3'd0, 5'd0,  5'd0,  5'd4,  32'h80000000, 32'h00C), 32'h010, 5'd4,  32'h80000000);
    add_vec(mk(OP_I,  0, 4'd13, 3'd5, 5'd4,  5'd0,  5'd5,  32'd4,        32'h010), 32'h014, 5'd5,  32'hF8000000);
    add_vec(mk(OP_I,  0, 4'd0,  3'd0, 5'd0,  5'd0,  5'd6,  32'd3,        32'h014), 32'h018, 5'd6,  32'd3);
    add_vec(mk(OP_R,  0, 4'd8,  3'd0, 5'd6,  5'd1,  5'd7,  32'd0,        32'h018), 32'h01C, 5'd7,  32'hFFFFFFFE);
    add_vec(mk(OP_R,  0, 4'd0,  3'd0, 5'd1,  5'd2,  5'd0,  32'd0,        32'h01C), 32'h020, 5'd0,  32'd0);
    add_vec(mk(OP_R,  0, 4'd2,  3'd0, 5'd5,  5'd1,  5'd8,  32'd0,        32'h020), 32'h024, 5'd8,  32'd1);
    add_vec(mk(OP_R,  0, 4'd3,  3'd0, 5'd1,  5'd5,  5'd9,  32'd0,        32'h024), 32'h028, 5'd9,  32'd1);
    add_vec(mk(OP_I,  0, 4'd4,  3'd0, 5'd3,  5'd0,  5'd10, 32'hFF,       32'h028), 32'h02C, 5'd10, 32'hF3);
    add_vec(mk(OP_I,  0, 4'd1,  3'd0, 5'd1,  5'd0,  5'd11, 32'd33,       32'h02C), 32'h030, 5'd11, 32'hA);
    add_vec(mk(OP_R,  0, 4'd5,  3'd0, 5'd4,  5'd1,  5'd12, 32'd0,        32'h030), 32'h034, 5'd12, 32'h04000000);
    add_vec(mk(OP_I,  0, 4'd7,  3'd0, 5'd3,  5'd0,  5'd13, 32'd4,        32'h034), 32'h038, 5'd13, 32'd4);
    add_vec(mk(OP_I,  0, 4'd6,  3'd0, 5'd3,  5'd0,  5'd14, 32'd1,        32'h038), 32'h03C, 5'd14, 32'hD);
    add_vec(mk(OP_U,  0, 4'd0,  3'd0, 5'd0,  5'd0,  5'd15, 32'h1000,     32'h100), 32'h104, 5'd15, 32'h1100);
    add_vec(mk(OP_I,  0, 4'd0,  3'd0, 5'd0,  5'd0,  5'd16, 32'hFFFFFFFF, 32'h104), 32'h108, 5'd16, 32'hFFFFFFFF);
    add_vec(mk(OP_BR, 0, 4'd0,  3'd6, 5'd8,  5'd16, 5'd17, 32'hFFFFFFF8, 32'h040), 32'h038, 5'd17, 32'd0);
    add_vec(mk(OP_BR, 0, 4'd0,  3'd0, 5'd1,  5'd2,  5'd17, 32'h20,       32'h050), 32'h054, 5'd17, 32'd0);
    add_vec(mk(OP_BR, 0, 4'd0,  3'd5, 5'd1,  5'd5,  5'd17, 32'h10,       32'h060), 32'h070, 5'd17, 32'd0);
    add_vec(mk(OP_BR, 0, 4'd0,  3'd1, 5'd1,  5'd2,  5'd17, 32'hFFFFFFF0, 32'h300), 32'h2F0, 5'd17, 32'd0);
    add_vec(mk(OP_JAL,0, 4'd0,  3'd0, 5'd0,  5'd0,  5'd18, 32'h100,      32'h080), 32'h180, 5'd18, 32'h84);
    add_vec(mk(OP_I,  0, 4'd0,  3'd0, 5'd0,  5'd0,  5'd19, 32'h101,      32'h084), 32'h088, 5'd19, 32'h101);
    add_vec(mk(OP_JALR,0,4'd0,  3'd0, 5'd19, 5'd0,  5'd20, 32'd0,        32'h200), 32'h100, 5'd20, 32'h204);
    add_vec(mk(OP_R,  0, 4'd13, 3'd0, 5'd7,  5'd1,  5'd21, 32'd0,        32'h304), 32'h308, 5'd21, 32'hFFFFFFFF);

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, mem_req, mem_we, trap_misaligned}, 5'b0);
    chk("rst_next_pc", next_pc, 32'd0);
    chk("rst_mem_bus", {mem_addr, mem_wdata, mem_wstrb}, 68'd0);
    rst = 1'b0;
    check_reg(5'd5, 32'd0);

    // Vector table: each non-memory instruction completes 2 cycles after start.
    for (int i = 0; i < vt.size(); i++) begin
      run_instr(vt[i].ins, 0, '0, vt[i].exp_npc, 1'b0);
      chk($sformatf("latency_v%0d", i), r_done_cyc, 64'd2);
      check_reg(vt[i].chk_reg, vt[i].chk_val);
    end

    // LB at 0x103 with three wait cycles.
    run_instr(mk(OP_LD, 0, 4'd0, 3'd0, 5'd0, 5'd0, 5'd21, 32'h103, 32'h400), 3, 32'h80FFFFFF,
              32'h404, 1'b0);
    chk("lb_done_cycle", r_done_cyc, 64'd6);
    chk("lb_req_cycles", r_req, 64'd4);
    chk("lb_addr", r_addr, 32'h103);
    chk("lb_addr_stable", r_addr_stable, 1'b1);
    chk("lb_we", r_we, 1'b0);
    check_reg(5'd21, 32'hFFFFFF80);

    // LHU at 0x102, zero wait.
    run_instr(mk(OP_LD, 0, 4'd0, 3'd5, 5'd0, 5'd0, 5'd22, 32'h102, 32'h404), 0, 32'h80FFFFFF,
              32'h408, 1'b0);
    chk("lhu_done_cycle", r_done_cyc, 64'd3);
    check_reg(5'd22, 32'h000080FF);

    // SH / SB of 0x1234ABCD.
    run_instr(mk(OP_U, 1, 4'd0, 3'd0, 5'd0, 5'd0, 5'd23, 32'h1234ABCD, 32'h408), 0, '0,
              32'h40C, 1'b0);
    run_instr(mk(OP_ST, 0, 4'd0, 3'd1, 5'd0, 5'd23, 5'd24, 32'h102, 32'h40C), 1, '0,
              32'h410, 1'b0);
    chk("sh_we", r_we, 1'b1);
    chk("sh_wstrb", r_wstrb, 4'b1100);
    chk("sh_wdata", r_wdata, 32'hABCDABCD);
    chk("sh_addr", r_addr, 32'h102);
    chk("sh_done_cycle", r_done_cyc, 64'd4);
    check_reg(5'd24, 32'd0);
    run_instr(mk(OP_ST, 0, 4'd0, 3'd0, 5'd0, 5'd23, 5'd0, 32'h101, 32'h410), 0, '0,
              32'h414, 1'b0);
    chk("sb_wstrb", r_wstrb, 4'b0010);
    chk("sb_wdata", r_wdata, 32'hCDCDCDCD);

    // Misaligned LW and doubleword on a 32-bit datapath.
    run_instr(mk(OP_LD, 0, 4'd0, 3'd2, 5'd0, 5'd0, 5'd21, 32'h101, 32'h500), 0, 32'h12345678,
              32'h500, 1'b1);
    chk("mis_lw_req", r_req, 64'd0);
    chk("mis_lw_done_cycle", r_done_cyc, 64'd2);
    check_reg(5'd21, 32'hFFFFFF80);
    run_instr(mk(OP_ST, 0, 4'd0, 3'd3, 5'd0, 5'd23, 5'd0, 32'h100, 32'h600), 0, '0,
              32'h600, 1'b1);
    chk("mis_sd_req", r_req, 64'd0);

    // Reset while waiting in MEM.
    @(negedge clk);
    drive(mk(OP_LD, 0, 4'd0, 3'd2, 5'd0, 5'd0, 5'd25, 32'h100, 32'h700));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mem_ready = 1'b0;
    seen = 1'b0;
    waitc = 0;
    while (!mem_req && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    chk("rst_mid_req_seen", mem_req, 1'b1);
    repeat (2) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctrl", {busy, done, mem_req}, 3'b000);
    rst = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    repeat (6) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    chk("rst_mid_no_done", seen, 1'b0);
    check_reg(5'd25, 32'd0);
    check_reg(5'd3, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
